// File: rtl/pipearch_dma_read_credit_sink_pkg.sv
// Shared types for the DMA read path: credit-length encodings and the
// credit-sink state machine states.
package pipearch_dma_read_credit_sink_pkg;

  localparam logic [1:0] CRED_LEN_1 = 2'b00;
  localparam logic [1:0] CRED_LEN_2 = 2'b01;
  localparam logic [1:0] CRED_LEN_4 = 2'b11;

  // Headroom that absorbs the one-cycle lag of the registered free-space value
  localparam int CRED_MARGIN = 4;

  typedef enum logic [1:0] {IDLE, RUN, DONE} t_sinkstate;

  function automatic logic [2:0] cred_lines(input logic [1:0] code);
    case (code)
      CRED_LEN_4: cred_lines = 3'd4;
      CRED_LEN_2: cred_lines = 3'd2;
      default:    cred_lines = 3'd1;
    endcase
  endfunction

endpackage

// File: rtl/pipearch_dma_read_credit_sink_fifo.sv
// Line FIFO on an inferred RAM; the registered RAM read doubles as the
// output register, so the head line appears two cycles after its push.
module pipearch_dma_read_credit_sink_fifo #(
  parameter int WIDTH      = 512,
  parameter int LOG2_DEPTH = 6
) (
  input  logic                  clk,
  input  logic                  srst,
  input  logic                  wr_en,
  input  logic [WIDTH-1:0]      wr_data,
  input  logic                  rd_en,
  output logic                  rd_valid,
  output logic [WIDTH-1:0]      rd_data,
  output logic [LOG2_DEPTH:0]   count,
  output logic                  full
);
  localparam int DEPTH = 2 ** LOG2_DEPTH;

  logic [WIDTH-1:0]    mem [DEPTH];
  logic [LOG2_DEPTH:0] wr_ptr_reg;
  logic [LOG2_DEPTH:0] rd_ptr_reg;
  logic                rd_valid_reg;
  logic [WIDTH-1:0]    rd_data_reg;
  logic [LOG2_DEPTH:0] mem_count;
  logic                wr_ok;
  logic                rd_ok;
  logic                load;

  assign mem_count = wr_ptr_reg - rd_ptr_reg;
  assign count     = mem_count + {{LOG2_DEPTH{1'b0}}, rd_valid_reg};
  assign full      = (count == (LOG2_DEPTH + 1)'(DEPTH));
  assign wr_ok     = wr_en && !full;
  assign rd_ok     = rd_en && rd_valid_reg;
  // Refill the output register whenever it is empty or being drained
  assign load      = (mem_count != '0) && (!rd_valid_reg || rd_ok);
  assign rd_valid  = rd_valid_reg;
  assign rd_data   = rd_data_reg;

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr_reg[LOG2_DEPTH-1:0]] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (load) rd_data_reg <= mem[rd_ptr_reg[LOG2_DEPTH-1:0]];
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      rd_valid_reg <= 1'b0;
    end else begin
      if (wr_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (load) begin
        rd_ptr_reg   <= rd_ptr_reg + 1'b1;
        rd_valid_reg <= 1'b1;
      end else if (rd_ok) begin
        rd_valid_reg <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/pipearch_dma_read_credit_sink.sv
// Consumer behind the CCI-P read DMA: grants 1/2/4-line read credits sized
// to free buffer space and re-streams returned lines with last marking.
module pipearch_dma_read_credit_sink
  import pipearch_dma_read_credit_sink_pkg::*;
#(
  parameter int LOG2_DEPTH = 6,
  parameter int LINE_WIDTH = 512,
  parameter int LEN_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [LEN_WIDTH-2:0]  cmd_num_lines,
  input  logic                  cmd_async,
  input  logic                  dma_active,
  output logic                  tx_re,
  output logic [1:0]            tx_rlength,
  input  logic                  tx_ralmostfull,
  input  logic                  rx_rvalid,
  input  logic [LINE_WIDTH-1:0] rx_rdata,
  output logic                  out_valid,
  output logic [LINE_WIDTH-1:0] out_data,
  output logic                  out_last,
  input  logic                  out_ready,
  output logic                  done,
  output logic                  overflow
);
  localparam int DEPTH = 2 ** LOG2_DEPTH;
  localparam int FW    = LEN_WIDTH + 1;

  t_sinkstate            state_reg;
  logic [LEN_WIDTH-1:0]  num_lines_reg;
  logic [LEN_WIDTH-1:0]  granted_reg;
  logic [LEN_WIDTH-1:0]  received_reg;
  logic [LEN_WIDTH-1:0]  popped_reg;
  logic                  async_reg;
  logic signed [FW-1:0]  free_reg;
  logic signed [FW-1:0]  free_next;
  logic                  cmd_ready_reg;
  logic                  tx_re_reg;
  logic [1:0]            tx_rlength_reg;
  logic                  done_reg;
  logic                  overflow_reg;

  logic                  fifo_valid;
  logic                  fifo_full;
  logic [LOG2_DEPTH:0]   fifo_count;
  logic                  in_run;
  logic                  accept;
  logic                  push;
  logic                  pop;
  logic [LEN_WIDTH-1:0]  rem;
  logic                  credit_ok;
  logic                  grant_en;
  logic [1:0]            grant_len;

  assign in_run    = (state_reg == RUN);
  assign accept    = (state_reg == IDLE) && cmd_valid && cmd_ready_reg;
  assign push      = in_run && rx_rvalid;
  assign pop       = fifo_valid && out_ready;
  assign rem       = num_lines_reg - granted_reg;
  assign free_next = FW'(DEPTH) - FW'(fifo_count) - (FW'(granted_reg) - FW'(received_reg));
  assign credit_ok = in_run && !async_reg && dma_active && !tx_ralmostfull
                     && (granted_reg < num_lines_reg);

  always_comb begin
    grant_en  = 1'b0;
    grant_len = CRED_LEN_1;
    if (credit_ok) begin
      if (rem >= 4 && free_reg >= $signed(FW'(4 + CRED_MARGIN))) begin
        grant_en  = 1'b1;
        grant_len = CRED_LEN_4;
      end else if (rem >= 2 && free_reg >= $signed(FW'(2 + CRED_MARGIN))) begin
        grant_en  = 1'b1;
        grant_len = CRED_LEN_2;
      end else if (free_reg >= $signed(FW'(1 + CRED_MARGIN))) begin
        grant_en  = 1'b1;
        grant_len = CRED_LEN_1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= IDLE;
      num_lines_reg  <= '0;
      granted_reg    <= '0;
      received_reg   <= '0;
      popped_reg     <= '0;
      async_reg      <= 1'b0;
      free_reg       <= FW'(DEPTH);
      cmd_ready_reg  <= 1'b0;
      tx_re_reg      <= 1'b0;
      tx_rlength_reg <= CRED_LEN_1;
      done_reg       <= 1'b0;
      overflow_reg   <= 1'b0;
    end else begin
      free_reg       <= free_next;
      tx_re_reg      <= 1'b0;
      tx_rlength_reg <= CRED_LEN_1;
      done_reg       <= 1'b0;
      if (push && fifo_full) overflow_reg <= 1'b1;
      case (state_reg)
        IDLE: begin
          cmd_ready_reg <= !accept;
          if (accept) begin
            num_lines_reg <= LEN_WIDTH'(cmd_num_lines);
            async_reg     <= cmd_async;
            granted_reg   <= '0;
            received_reg  <= '0;
            popped_reg    <= '0;
            state_reg     <= (cmd_num_lines == '0) ? DONE : RUN;
          end
        end
        RUN: begin
          cmd_ready_reg <= 1'b0;
          if (grant_en) begin
            tx_re_reg      <= 1'b1;
            tx_rlength_reg <= grant_len;
            granted_reg    <= granted_reg + LEN_WIDTH'(cred_lines(grant_len));
          end
          if (rx_rvalid) received_reg <= received_reg + LEN_WIDTH'(1);
          if (pop) popped_reg <= popped_reg + LEN_WIDTH'(1);
          if (popped_reg == num_lines_reg) state_reg <= DONE;
        end
        DONE: begin
          cmd_ready_reg <= 1'b0;
          done_reg      <= 1'b1;
          state_reg     <= IDLE;
        end
        default: begin
          cmd_ready_reg <= 1'b0;
          state_reg     <= IDLE;
        end
      endcase
    end
  end

  pipearch_dma_read_credit_sink_fifo #(
    .WIDTH      (LINE_WIDTH),
    .LOG2_DEPTH (LOG2_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .srst     (reset),
    .wr_en    (push),
    .wr_data  (rx_rdata),
    .rd_en    (pop),
    .rd_valid (fifo_valid),
    .rd_data  (out_data),
    .count    (fifo_count),
    .full     (fifo_full)
  );

  assign cmd_ready  = cmd_ready_reg;
  assign tx_re      = tx_re_reg;
  assign tx_rlength = tx_rlength_reg;
  assign out_valid  = fifo_valid;
  assign out_last   = fifo_valid && (popped_reg == num_lines_reg - LEN_WIDTH'(1));
  assign done       = done_reg;
  assign overflow   = overflow_reg;

endmodule

// File: doc/pipearch_dma_read_credit_sink.md
Name: pipearch_dma_read_credit_sink

Overview:
- Consumer stage directly downstream of the CCI-P read DMA engine.
- Accepts one line-load command at a time and grants read credits to the DMA as 1/2/4-line chunks on the DMA's tx_re/tx_rlength request lines, sized to its own free buffer space.
- Buffers the returned 512-bit lines in an internal FIFO and presents them to the compute pipeline as a valid/ready stream with last-line marking, since the DMA's rx path has no backpressure.

Parameters:
LOG2_DEPTH, 6, log2 of internal line FIFO depth (DEPTH = 2**LOG2_DEPTH, min 4)
LINE_WIDTH, 512, bits per cache line
LEN_WIDTH, 32, width of line counters and cmd_num_lines

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
cmd_valid  in  1  command present
cmd_ready  out  1  high in IDLE; command accepted when cmd_valid && cmd_ready
cmd_num_lines  in  31  number of lines this command delivers
cmd_async  in  1  1 = DMA runs without credits; no tx_re issued
dma_active  in  1  DMA request side is in its read state (credits counted only then)
tx_re  out  1  credit pulse to DMA
tx_rlength  out  2  credit size: 2'b00 = 1 line, 2'b01 = 2 lines, 2'b11 = 4 lines
tx_ralmostfull  in  1  DMA-side almost-full; no credit issued while high
rx_rvalid  in  1  line from DMA valid this cycle
rx_rdata  in  LINE_WIDTH  line data
out_valid  out  1  stream line valid
out_data  out  LINE_WIDTH  stream line
out_last  out  1  qualifies final line of the command
out_ready  in  1  consumer accepts line
done  out  1  one-cycle pulse when final line is consumed
overflow  out  1  sticky error: rx_rvalid while FIFO full

Behaviour:
- Reset values: cmd_ready 0 during reset, then 1 (IDLE); tx_re 0, tx_rlength 0, out_valid 0, out_last 0, done 0, overflow 0. All counters are zeroed and the FIFO is flushed.
- Reset mid-operation behaves identically: the state returns to IDLE, any in-flight line is dropped, and no credit pulse is emitted in the cycle after reset.
- States:
  - IDLE: on accept, latch num_lines and async; zero the counters granted, received and popped. Go to RUN, or to DONE if num_lines == 0.
  - RUN: issue credits and accept lines. Go to DONE in the cycle after popped reaches num_lines.
  - DONE: done = 1 for one cycle, then IDLE.
- Credit rule (RUN, !async, dma_active, !tx_ralmostfull, granted < num_lines):
  - free = DEPTH - fifo_count - (granted - received), computed signed and registered one cycle earlier (the grant decision uses the previous-cycle value).
  - rem = num_lines - granted.
  - Grant 4 if rem >= 4 and free >= 4 + 4 (4 lines margin for the registered lag). Otherwise grant 2 if rem >= 2 and free >= 2 + 4. Otherwise grant 1 if free >= 1 + 4.
  - At most one grant per cycle. tx_re and tx_rlength are registered one-cycle pulses; granted increments in the same cycle tx_re is driven.
  - With cmd_async = 1, tx_re is never asserted.
- Receive:
  - Each rx_rvalid in RUN pushes rx_rdata into the FIFO and increments received.
  - rx_rvalid outside RUN is ignored.
  - rx_rvalid while the FIFO is full drops the line and sets overflow (sticky until reset).
  - Simultaneous push and pop is allowed.
- Output:
  - out_valid = FIFO non-empty (registered read, first-word latency 2 cycles after push).
  - A line is consumed when out_valid && out_ready; popped increments on each consume.
  - out_last = out_valid && (popped == num_lines - 1).
  - out_data is held stable while out_valid && !out_ready.
- Arithmetic: counters are LEN_WIDTH unsigned; no counter wraps within a command (num_lines < 2**31).
- Boundaries:
  - Full FIFO: no credit is issued.
  - rem < chunk: a smaller chunk is chosen.
  - A new cmd_valid in any non-IDLE state is held off (cmd_ready 0).

Decomposition:
- Shared pkg: credit-length encodings (CRED_LEN_1/2/4 = 2'b00/01/11) and the state enum t_sinkstate {IDLE, RUN, DONE}, placed next to the existing DMA state typedefs.
- One sub-module: the codebase's existing fifo instantiated with width LINE_WIDTH and depth LOG2_DEPTH; no other children.

Test Plan:
- num_lines=10, async=0, dma_active=1, out_ready=1, DMA model returns credited lines after 20 cycles -> tx_rlength sequence 11, 11, 01 (total 10); 10 lines emitted in order; out_last on the 10th; done pulse once; overflow 0.
- num_lines=100, DEPTH=64, out_ready=0 -> credits stop when in-flight + FIFO >= 60; no overflow. Raise out_ready -> credits resume; all 100 lines delivered.
- num_lines=0 -> no tx_re; done pulses two cycles after accept; cmd_ready high again the next cycle.
- async=1, num_lines=8, DMA pushes 8 lines back-to-back -> no tx_re; 8 lines out; done.
- Force 65 rx_rvalid pulses with out_ready=0, DEPTH=64 -> overflow sets on the 65th and stays high; 64 lines retained.
- Reset at line 5 of 10 -> all outputs return to reset values next cycle; a new command of 3 lines completes cleanly with tx_rlength 01, 00.
